monolith_perm_ctrl: RTL and testbench
=====================================

// Module: monolith_perm_ctrl
// PURPOSE
//  Sequences one full Monolith-31 permutation over an external round datapath (bars/bricks/concrete + RC).
//  Accepts a STATE_SIZE-word state via valid/ready and holds it in an internal state register.
//  Issues NUM_ROUNDS+1 datapath passes: an INIT pass (concrete only), then NUM_ROUNDS full rounds.
//  Returns the permuted state via valid/ready. Sits between the sponge/hash front-end and the round datapath.
// PARAMETERS
//  WORD_WIDTH    31  field element width (M31, p = 2^31-1)
//  STATE_SIZE    16  words per state
//  NUM_ROUNDS     6  full rounds after the INIT pass
//  ROUND_LATENCY  1  cycles from dp_state stable to dp_result valid (>=1; pipelined datapath allowed)
// PORTS
//  clk        in   1                       clock
//  reset      in   1                       asynchronous, active-high reset
//  in_valid   in   1                       input state offered
//  in_ready   out  1                       controller can accept a state
//  in_state   in   [WW-1:0] x STATE_SIZE   input state
//  out_valid  out  1                       permuted state available
//  out_ready  in   1                       consumer accepts output
//  out_state  out  [WW-1:0] x STATE_SIZE   permuted state (= state register)
//  dp_state   out  [WW-1:0] x STATE_SIZE   state presented to round datapath (= state register)
//  dp_mode    out  1                       0 = INIT (concrete only), 1 = FULL round
//  dp_rc_idx  out  $clog2(NUM_ROUNDS+1)    round-constant index for current pass
//  dp_rc_en   out  1                       1 = add RC[dp_rc_idx]; 0 on INIT and last full round
//  dp_result  in   [WW-1:0] x STATE_SIZE   datapath output, valid ROUND_LATENCY cycles after dp_state
//  busy       out  1                       high in RUN and DONE
// BEHAVIOUR
//  Reset (async, any state incl. mid-permutation): FSM=IDLE; state reg, pass cnt, wait cnt = 0;
//   in_ready=1, out_valid=0, busy=0, dp_mode=0, dp_rc_idx=0, dp_rc_en=0. In-flight permutation is dropped.
//  FSM IDLE -> RUN -> DONE -> IDLE.
//  IDLE: in_ready=1. On in_valid&in_ready edge: state reg <= in_state, pass=0, wait=0, -> RUN.
//  RUN: in_ready=0. Pass p (0..NUM_ROUNDS) lasts exactly ROUND_LATENCY cycles; state reg held stable.
//   dp_mode=(p!=0); dp_rc_idx=(p==0)?0:p-1; dp_rc_en=(p!=0)&&(p!=NUM_ROUNDS).
//   wait counts 0..ROUND_LATENCY-1; on edge with wait==ROUND_LATENCY-1: state reg <= dp_result, wait<=0,
//   and if p==NUM_ROUNDS -> DONE, else p<=p+1.
//  Latency: out_valid rises (NUM_ROUNDS+1)*ROUND_LATENCY cycles after the input handshake edge (7 at defaults).
//  DONE: out_valid=1, out_state stable until out_valid&out_ready edge -> IDLE. No new input accepted in DONE.
//   in_ready not asserted combinationally from out_ready (no same-cycle output/input turnaround; min 1 IDLE cycle).
//  in_valid while busy: ignored, no side effects. out_ready outside DONE: ignored.
//  No arithmetic in this block: dp_result is captured verbatim (datapath owns mod reduction).
//  Counters saturate by construction; pass never exceeds NUM_ROUNDS, wait never exceeds ROUND_LATENCY-1.
//  Elaboration check: ROUND_LATENCY>=1, NUM_ROUNDS>=1, else $fatal.
// STRUCTURE
//  monolith_pkg: M31 prime constant, WORD_WIDTH/STATE_SIZE/NUM_ROUNDS defaults, state_t array typedef,
//   dp_mode_e {DP_INIT, DP_FULL}, ctrl FSM enum {ST_IDLE, ST_RUN, ST_DONE}.
//  Single module, no sub-modules: FSM + pass counter + wait counter + state register.
//  Round datapath instantiated by the parent, not inside this block.
// TESTING (bench stub datapath: dp_result[i] = dp_state[i] + 1 + dp_rc_en, ROUND_LATENCY-cycle delay line)
//  1. Defaults, in_state all 0, out_ready=1 -> out_valid exactly 7 cycles after accept; every word = 12
//     (7 passes +1, rc_en on passes 1..5 -> +5).
//  2. Trace dp signals: pass0 mode=0,rc_en=0; passes1-5 mode=1,rc_idx=0..4,rc_en=1; pass6 mode=1,rc_idx=5,rc_en=0.
//  3. ROUND_LATENCY=3, in_state[i]=i -> out_valid after 21 cycles, out_state[i]=i+12; dp_state constant within passes.
//  4. out_ready=0 for 10 cycles in DONE -> out_valid/out_state held; in_valid pulses ignored; then accept -> IDLE, in_ready=1.
//  5. Assert reset at pass 3 -> next cycle in_ready=1, out_valid=0, busy=0; new state 0 completes with result 12.
//  6. Back-to-back: in_valid held high, out_ready=1 -> second accept one cycle after output handshake; both results correct.

Source files
------------

// File: rtl/monolith_pkg.sv
// Shared constants and types for the Monolith-31 permutation controller and its users.
package monolith_pkg;

    localparam logic [30:0] M31_P = 31'h7FFF_FFFF;

    localparam int DEFAULT_WORD_WIDTH = 31;
    localparam int DEFAULT_STATE_SIZE = 16;
    localparam int DEFAULT_NUM_ROUNDS = 6;

    typedef logic [DEFAULT_STATE_SIZE-1:0][DEFAULT_WORD_WIDTH-1:0] state_t;

    typedef enum logic {
        DP_INIT = 1'b0,
        DP_FULL = 1'b1
    } dp_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } ctrl_state_e;

endpackage

// File: rtl/monolith_perm_ctrl_if.sv
// State-in / state-out valid-ready streams between the sponge front-end and the permutation controller.
interface monolith_perm_ctrl_if
    import monolith_pkg::*;
#(
    parameter int WORD_WIDTH = DEFAULT_WORD_WIDTH,
    parameter int STATE_SIZE = DEFAULT_STATE_SIZE
);
    logic                                  in_valid;
    logic                                  in_ready;
    logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] in_state;
    logic                                  out_valid;
    logic                                  out_ready;
    logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] out_state;

    modport master (
        output in_valid, in_state, out_ready,
        input  in_ready, out_valid, out_state
    );

    modport slave (
        input  in_valid, in_state, out_ready,
        output in_ready, out_valid, out_state
    );
endinterface

// File: rtl/monolith_perm_ctrl.sv
// Sequences one Monolith-31 permutation: an INIT pass then NUM_ROUNDS full rounds over an external
// round datapath, holding the state in a local register between passes.
module monolith_perm_ctrl
    import monolith_pkg::*;
#(
    parameter int WORD_WIDTH    = DEFAULT_WORD_WIDTH,
    parameter int STATE_SIZE    = DEFAULT_STATE_SIZE,
    parameter int NUM_ROUNDS    = DEFAULT_NUM_ROUNDS,
    parameter int ROUND_LATENCY = 1,
    localparam int RC_W         = $clog2(NUM_ROUNDS + 1)
) (
    input  logic                                  clk,
    input  logic                                  reset,
    monolith_perm_ctrl_if.slave                   bus,
    output logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] dp_state,
    output logic                                  dp_mode,
    output logic [RC_W-1:0]                       dp_rc_idx,
    output logic                                  dp_rc_en,
    input  logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] dp_result,
    output logic                                  busy
);

    localparam int              WAIT_W    = (ROUND_LATENCY > 1) ? $clog2(ROUND_LATENCY) : 1;
    localparam logic [RC_W-1:0]   LAST_PASS = RC_W'(NUM_ROUNDS);
    localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(ROUND_LATENCY - 1);

    if (ROUND_LATENCY < 1 || NUM_ROUNDS < 1) begin : g_param_chk
        $fatal(1, "monolith_perm_ctrl: ROUND_LATENCY and NUM_ROUNDS must both be >= 1");
    end

    ctrl_state_e                           st_q;
    ctrl_state_e                           st_d;
    logic [RC_W-1:0]                       pass_q;
    logic [WAIT_W-1:0]                     wait_q;
    logic [STATE_SIZE-1:0][WORD_WIDTH-1:0] state_q;
    logic                                  accept;
    logic                                  pass_end;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            st_q <= ST_IDLE;
        end else begin
            st_q <= st_d;
        end
    end

    // The last full round skips the round constant, so rc_en drops on pass NUM_ROUNDS.
    always_comb begin
        st_d          = st_q;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        busy          = 1'b0;
        dp_mode       = DP_INIT;
        dp_rc_idx     = '0;
        dp_rc_en      = 1'b0;
        accept        = 1'b0;
        pass_end      = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    accept = 1'b1;
                    st_d   = ST_RUN;
                end
            end
            ST_RUN: begin
                busy     = 1'b1;
                pass_end = (wait_q == LAST_WAIT);
                if (pass_q != '0) begin
                    dp_mode   = DP_FULL;
                    dp_rc_idx = pass_q - RC_W'(1);
                    dp_rc_en  = (pass_q != LAST_PASS);
                end
                if (pass_end && (pass_q == LAST_PASS)) begin
                    st_d = ST_DONE;
                end
            end
            ST_DONE: begin
                busy          = 1'b1;
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    st_d = ST_IDLE;
                end
            end
            default: st_d = ST_IDLE;
        endcase
    end

    // State register only moves on accept or at the end of a pass; it is held for the whole pass.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= '0;
            pass_q  <= '0;
            wait_q  <= '0;
        end else if (accept) begin
            state_q <= bus.in_state;
            pass_q  <= '0;
            wait_q  <= '0;
        end else if (st_q == ST_RUN) begin
            if (pass_end) begin
                state_q <= dp_result;
                wait_q  <= '0;
                if (pass_q != LAST_PASS) begin
                    pass_q <= pass_q + RC_W'(1);
                end
            end else begin
                wait_q <= wait_q + WAIT_W'(1);
            end
        end
    end

    assign dp_state      = state_q;
    assign bus.out_state = state_q;

endmodule

// File: tb/tb_monolith_perm_ctrl.sv
// Bench for monolith_perm_ctrl: two instances (round latency 1 and 3) driven by stub datapaths.
module tb_monolith_perm_ctrl;
    import monolith_pkg::*;

    localparam int NR = 6;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    monolith_perm_ctrl_if #(.WORD_WIDTH(31), .STATE_SIZE(16)) bus1 ();
    monolith_perm_ctrl_if #(.WORD_WIDTH(31), .STATE_SIZE(16)) bus3 ();

    state_t     dps1, dpr1, dps3, dpr3;
    logic       md1, en1, bz1, md3, en3, bz3;
    logic [2:0] idx1, idx3;

    monolith_perm_ctrl #(.ROUND_LATENCY(1)) u_dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .dp_state(dps1), .dp_mode(md1),
        .dp_rc_idx(idx1), .dp_rc_en(en1), .dp_result(dpr1), .busy(bz1)
    );

    monolith_perm_ctrl #(.ROUND_LATENCY(3)) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3), .dp_state(dps3), .dp_mode(md3),
        .dp_rc_idx(idx3), .dp_rc_en(en3), .dp_result(dpr3), .busy(bz3)
    );

    function automatic state_t stub(input state_t s, input logic en);
        state_t r;
        for (int i = 0; i < 16; i++) r[i] = s[i] + 31'd1 + {30'd0, en};
        return r;
    endfunction

    function automatic state_t addw(input state_t s, input int n);
        state_t r;
        for (int i = 0; i < 16; i++) r[i] = s[i] + 31'(n);
        return r;
    endfunction

    // Stub datapaths: combinational for latency 1, two extra registers for latency 3.
    state_t p3a, p3b;
    assign dpr1 = stub(dps1, en1);
    always @(posedge clk) begin
        p3a <= stub(dps3, en3);
        p3b <= p3a;
    end
    assign dpr3 = p3b;

    logic   tiv[2], tordy[2];
    state_t tist[2];
    assign bus1.in_valid  = tiv[0];
    assign bus1.in_state  = tist[0];
    assign bus1.out_ready = tordy[0];
    assign bus3.in_valid  = tiv[1];
    assign bus3.in_state  = tist[1];
    assign bus3.out_ready = tordy[1];

    logic       ir[2], ov[2], bz[2], md[2], en[2];
    logic [2:0] idx[2];
    state_t     ost[2], dps[2];
    assign ir[0] = bus1.in_ready;   assign ir[1] = bus3.in_ready;
    assign ov[0] = bus1.out_valid;  assign ov[1] = bus3.out_valid;
    assign ost[0] = bus1.out_state; assign ost[1] = bus3.out_state;
    assign bz[0] = bz1;   assign bz[1] = bz3;
    assign md[0] = md1;   assign md[1] = md3;
    assign en[0] = en1;   assign en[1] = en3;
    assign idx[0] = idx1; assign idx[1] = idx3;
    assign dps[0] = dps1; assign dps[1] = dps3;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    endtask

    task automatic chks(input string nm, input state_t act, input state_t exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, want %h", nm, act, exp);
    endtask

    // Reference model: phase (0 idle, 1 running, 2 done) plus cycles elapsed since accept.
    function automatic int rl(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    // Total added to each word after p completed passes: +1 per pass, +1 more for rc-enabled passes 1..NR-1.
    function automatic int inc(input int p);
        int e;
        e = (p < 2) ? 0 : (((p - 1) < (NR - 1)) ? (p - 1) : (NR - 1));
        return p + e;
    endfunction

    int     ph[2], k[2];
    state_t m_in[2], m_reg[2];

    always @(posedge clk or posedge reset) begin
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                ph[d]    <= 0;
                k[d]     <= 0;
                m_reg[d] <= '0;
            end else begin
                case (ph[d])
                    0: if (tiv[d]) begin
                        m_in[d] <= tist[d];
                        k[d]    <= 0;
                        ph[d]   <= 1;
                    end
                    1: begin
                        k[d] <= k[d] + 1;
                        if (k[d] + 1 == (NR + 1) * rl(d)) begin
                            ph[d]    <= 2;
                            m_reg[d] <= addw(m_in[d], inc(NR + 1));
                        end
                    end
                    2: if (tordy[d]) ph[d] <= 0;
                    default: ph[d] <= 0;
                endcase
            end
        end
    end

    function automatic int cur_pass(input int d);
        return (ph[d] == 1) ? k[d] / rl(d) : 0;
    endfunction

    function automatic logic [2:0] exp_hs(input int d);
        return (ph[d] == 0) ? 3'b100 : ((ph[d] == 1) ? 3'b001 : 3'b011);
    endfunction

    function automatic logic [4:0] exp_dp(input int d);
        int p;
        p = cur_pass(d);
        if (ph[d] != 1) return 5'b0;
        return {p != 0, 3'((p == 0) ? 0 : p - 1), (p != 0) && (p != NR)};
    endfunction

    function automatic state_t exp_reg(input int d);
        return (ph[d] == 1) ? addw(m_in[d], inc(cur_pass(d))) : m_reg[d];
    endfunction

    logic chk_on = 1'b0;

    always @(negedge clk) begin
        if (chk_on) begin
            for (int d = 0; d < 2; d++) begin
                chk($sformatf("rl%0d ready/valid/busy", rl(d)), {ir[d], ov[d], bz[d]}, exp_hs(d));
                chk($sformatf("rl%0d mode/rc_idx/rc_en", rl(d)), {md[d], idx[d], en[d]}, exp_dp(d));
                chks($sformatf("rl%0d dp_state", rl(d)), dps[d], exp_reg(d));
                chks($sformatf("rl%0d out_state", rl(d)), ost[d], exp_reg(d));
            end
        end
    end

    logic [4:0] tr[7];
    logic [4:0] tr_exp[7] = '{5'b0_000_0, 5'b1_000_1, 5'b1_001_1, 5'b1_010_1,
                              5'b1_011_1, 5'b1_100_1, 5'b1_101_0};

    task automatic run_one(input int d, input state_t s, input int bound,
                           output int lat, output state_t res);
        @(posedge clk); #1;
        tist[d] = s; tiv[d] = 1'b1; tordy[d] = 1'b1;
        @(posedge clk); #1;
        tiv[d] = 1'b0;
        lat = -1;
        res = '0;
        for (int n = 0; n < bound; n++) begin
            @(negedge clk);
            if (d == 0 && n < 7) tr[n] = {md[0], idx[0], en[0]};
            if (ov[d]) begin
                lat = n;
                res = ost[d];
                break;
            end
        end
        if (lat < 0) chk($sformatf("rl%0d out_valid timeout", rl(d)), 64'd0, 64'd1);
    endtask

    initial begin
        int     lat, no1, no2, na2, seen;
        state_t s, res, ra, rb;
        reset = 1'b1;
        for (int d = 0; d < 2; d++) begin
            tiv[d] = 1'b0; tordy[d] = 1'b0; tist[d] = '0;
        end
        @(posedge clk); #1;
        chk_on = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("reset in_ready", {63'd0, ir[0]}, 64'd1);
        chk("reset out_valid/busy", {62'd0, ov[0], bz[0]}, 64'd0);
        chk("reset dp ctrl", {59'd0, md[1], idx[1], en[1]}, 64'd0);

        // Zero state, latency 1: latency 7, every word 12, pass-by-pass control trace.
        run_one(0, '0, 40, lat, res);
        chk("rl1 latency", 64'(lat), 64'd7);
        chk("rl1 word0", {33'd0, res[0]}, 64'd12);
        chk("rl1 word15", {33'd0, res[15]}, 64'd12);
        for (int p = 0; p < 7; p++) chk($sformatf("trace pass%0d", p), {59'd0, tr[p]}, {59'd0, tr_exp[p]});

        // Ramp state, latency 3.
        for (int i = 0; i < 16; i++) s[i] = 31'(i);
        run_one(1, s, 80, lat, res);
        chk("rl3 latency", 64'(lat), 64'd21);
        chk("rl3 word5", {33'd0, res[5]}, 64'd17);
        chk("rl3 word15", {33'd0, res[15]}, 64'd27);

        // Back-pressure in DONE with stray in_valid pulses.
        for (int i = 0; i < 16; i++) s[i] = 31'(100 + i);
        @(posedge clk); #1;
        tist[0] = s; tiv[0] = 1'b1; tordy[0] = 1'b0;
        @(posedge clk); #1;
        tiv[0] = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (ov[0]) begin seen = 1; break; end
        end
        chk("stall reach done", 64'(seen), 64'd1);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            tiv[0] = c[0];
            tist[0] = addw(s, 50);
            @(negedge clk);
            chk("stall out_valid held", {63'd0, ov[0]}, 64'd1);
            chk("stall word3 held", {33'd0, ost[0][3]}, 64'd115);
        end
        @(posedge clk); #1;
        tiv[0] = 1'b0; tordy[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("after drain in_ready", {63'd0, ir[0]}, 64'd1);
        chk("after drain out_valid", {63'd0, ov[0]}, 64'd0);

        // Reset in the middle of pass 3.
        @(posedge clk); #1;
        tist[0] = addw('0, 5); tiv[0] = 1'b1;
        @(posedge clk); #1;
        tiv[0] = 1'b0;
        repeat (4) @(negedge clk);
        chk("pass3 rc_idx", {61'd0, idx[0]}, 64'd2);
        #2 reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk);
        chk("midrun reset ready/valid/busy", {61'd0, ir[0], ov[0], bz[0]}, 64'b100);
        chk("midrun reset state word0", {33'd0, dps[0][0]}, 64'd0);
        run_one(0, '0, 40, lat, res);
        chk("post-reset latency", 64'(lat), 64'd7);
        chk("post-reset word7", {33'd0, res[7]}, 64'd12);

        // Back-to-back with in_valid held high.
        @(posedge clk); #1;
        tist[0] = addw('0, 7); tiv[0] = 1'b1; tordy[0] = 1'b1;
        no1 = -1; no2 = -1; na2 = -1; ra = '0; rb = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (i == 1) tist[0] = addw('0, 20);
            if (ov[0]) begin
                if (no1 < 0) begin
                    no1 = i; ra = ost[0];
                end else begin
                    no2 = i; rb = ost[0]; tiv[0] = 1'b0;
                    break;
                end
            end else if (ir[0] && no1 >= 0 && na2 < 0) begin
                na2 = i;
            end
        end
        chk("b2b first output", 64'(no1), 64'd8);
        chk("b2b second accept", 64'(na2), 64'd9);
        chk("b2b second output", 64'(no2), 64'd17);
        chk("b2b first word0", {33'd0, ra[0]}, 64'd19);
        chk("b2b second word4", {33'd0, rb[4]}, 64'd32);

        @(posedge clk);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
